// File: rtl/omsp_spm_protect_seq_pkg.sv
// Shared definitions for the SPM protect/unprotect sequencer.
package omsp_spm_protect_seq_pkg;

  // Key width in bits, shared with the SPM array.
  localparam int SECURITY  = 64;
  // Number of 16-bit key words streamed after a successful protect.
  localparam int KEY_WORDS = SECURITY / 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UPDATE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_KEY    = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/omsp_spm_protect_seq.sv
// Protect/unprotect sequencer: issues the SPM update pulse, checks the
// violation flag, streams the derived key on protect and returns one
// pass/fail response per command.
module omsp_spm_protect_seq #(
  parameter int SECURITY     = omsp_spm_protect_seq_pkg::SECURITY,
  parameter int KEY_WORDS    = SECURITY / 16,
  parameter int KEY_IDX_SIZE = 2
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_enable,
  output logic                    update_spm,
  output logic                    enable_spm,
  input  logic                    violation,
  input  logic                    kd_valid,
  input  logic [15:0]             kd_data,
  output logic                    kd_ready,
  output logic                    write_key,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    rsp_valid,
  output logic                    rsp_ok,
  input  logic                    rsp_ready,
  output logic                    busy
);
  import omsp_spm_protect_seq_pkg::*;

  localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(KEY_WORDS - 1);

  state_e                  state_q, state_d;
  logic [KEY_IDX_SIZE-1:0] cnt_q, cnt_d;
  logic                    en_q, en_d;
  logic                    ok_q, ok_d;

  // State, word counter, latched enable and result register.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ok_q    <= ok_d;
    end
  end

  // Next-state logic; a violation during KEY beats a same-cycle key write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    ok_d    = ok_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          en_d    = cmd_enable;
          cnt_d   = '0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (violation) begin
          ok_d    = 1'b0;
          state_d = ST_RESP;
        end else if (en_q) begin
          state_d = ST_KEY;
        end else begin
          ok_d    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_KEY: begin
        if (violation) begin
          ok_d    = 1'b0;
          state_d = ST_RESP;
        end else if (kd_valid) begin
          if (cnt_q == LAST_IDX) begin
            // Last word: leave the counter at its final index, no wrap.
            ok_d    = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign update_spm = (state_q == ST_UPDATE);
  assign enable_spm = en_q;
  assign kd_ready   = (state_q == ST_KEY);
  assign write_key  = (state_q == ST_KEY) && kd_valid && !violation;
  assign key_in     = kd_data;
  assign key_idx    = cnt_q;
  assign rsp_valid  = (state_q == ST_RESP);
  // The result register keeps its last value; only expose it with a response.
  assign rsp_ok     = (state_q == ST_RESP) && ok_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_omsp_spm_protect_seq.sv
// Scoreboard bench for omsp_spm_protect_seq: the stimulus pushes expected
// update pulses, key writes and responses (with their cycle numbers); a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_omsp_spm_protect_seq;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        cmd_valid, cmd_ready, cmd_enable;
  logic        update_spm, enable_spm, violation;
  logic        kd_valid, kd_ready, write_key;
  logic [15:0] kd_data, key_in;
  logic [1:0]  key_idx;
  logic        rsp_valid, rsp_ok, rsp_ready, busy;

  omsp_spm_protect_seq dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_enable(cmd_enable),
    .update_spm(update_spm), .enable_spm(enable_spm), .violation(violation),
    .kd_valid(kd_valid), .kd_data(kd_data), .kd_ready(kd_ready),
    .write_key(write_key), .key_in(key_in), .key_idx(key_idx),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          c;
  } ev_t;

  ev_t q_upd[$];
  ev_t q_wr[$];
  ev_t q_rsp[$];

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit rsp_prev = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic ev_t mk(input logic [15:0] a, input logic [15:0] b, input int c);
    ev_t e;
    e.a = a;
    e.b = b;
    e.c = c;
    return e;
  endfunction

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  always @(negedge mclk) begin
    ev_t e;
    if (mon_en) begin
      if (update_spm) begin
        if (q_upd.size() == 0) chk("upd_unexpected", 32'd1, 32'd0);
        else begin
          e = q_upd.pop_front();
          chk("upd_enable", 32'(enable_spm), 32'(e.a));
          chk("upd_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (write_key) begin
        if (q_wr.size() == 0) chk("wr_unexpected", {16'd0, key_in}, 32'hFFFF_FFFF);
        else begin
          e = q_wr.pop_front();
          chk("wr_idx", 32'(key_idx), 32'(e.a));
          chk("wr_data", 32'(key_in), 32'(e.b));
          chk("wr_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (rsp_valid && !rsp_prev) begin
        if (q_rsp.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = q_rsp.pop_front();
          chk("rsp_ok", 32'(rsp_ok), 32'(e.a));
          chk("rsp_cycle", 32'(cyc), 32'(e.c));
        end
      end
      rsp_prev = rsp_valid;
    end
  end

  // One command. viol_chk raises violation in CHECK; toggle alternates
  // kd_valid starting high; viol_idx raises violation with kd_valid at that
  // word; stall holds rsp_ready low and keeps a new cmd_valid pending.
  task automatic issue(input bit en, input bit viol_chk, input bit toggle,
                       input int viol_idx, input int stall);
    int          t;
    int          idx;
    int          guard;
    bit          ph;
    bit          done;
    bit          exp_ok;
    logic [15:0] d;
    tick();
    cmd_valid  = 1'b1;
    cmd_enable = en;
    t = cyc;
    q_upd.push_back(mk(16'(en), 16'd0, t + 1));
    tick();
    cmd_valid = 1'b0;
    kd_valid  = 1'b0;
    tick();
    violation = viol_chk;
    if (viol_chk || !en) begin
      exp_ok = !viol_chk;
      q_rsp.push_back(mk(16'(exp_ok), 16'd0, t + 3));
    end else begin
      idx = 0; ph = 1'b1; done = 1'b0; guard = 0; exp_ok = 1'b0;
      while (!done && guard < 20) begin
        guard++;
        tick();
        violation = 1'b0;
        kd_valid  = toggle ? ph : 1'b1;
        ph        = !ph;
        d         = 16'(16'h1111 * (idx + 1));
        kd_data   = d;
        if (kd_valid && idx == viol_idx) begin
          violation = 1'b1;
          exp_ok = 1'b0;
          q_rsp.push_back(mk(16'd0, 16'd0, cyc + 1));
          done = 1'b1;
        end else if (kd_valid) begin
          q_wr.push_back(mk(16'(idx), d, cyc));
          idx++;
          if (idx == 4) begin
            exp_ok = 1'b1;
            q_rsp.push_back(mk(16'd1, 16'd0, cyc + 1));
            done = 1'b1;
          end
        end
      end
    end
    tick();
    violation = 1'b0;
    kd_valid  = 1'b0;
    if (stall > 0) begin
      rsp_ready  = 1'b0;
      cmd_valid  = 1'b1;
      cmd_enable = 1'b0;
      for (int i = 0; i < stall; i++) begin
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall_rsp_ok", 32'(rsp_ok), 32'(exp_ok));
        chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        tick();
      end
      rsp_ready = 1'b1;
      chk("stall_rsp_hold", 32'(rsp_valid), 32'd1);
    end
  endtask

  initial begin
    int t;
    puc_rst = 1'b1; cmd_valid = 1'b0; cmd_enable = 1'b0; violation = 1'b0;
    kd_valid = 1'b0; kd_data = 16'd0; rsp_ready = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_update", 32'(update_spm), 32'd0);
    chk("rst_enable", 32'(enable_spm), 32'd0);
    chk("rst_kd_ready", 32'(kd_ready), 32'd0);
    chk("rst_write_key", 32'(write_key), 32'd0);
    chk("rst_key_idx", 32'(key_idx), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_ok", 32'(rsp_ok), 32'd0);
    puc_rst = 1'b0;
    mon_en  = 1'b1;

    issue(1'b1, 1'b0, 1'b0, -1, 0);  // protect, kd_valid held
    issue(1'b0, 1'b0, 1'b0, -1, 0);  // unprotect
    issue(1'b1, 1'b1, 1'b0, -1, 0);  // protect, violation in CHECK
    issue(1'b1, 1'b0, 1'b1, -1, 0);  // protect, kd_valid toggling
    issue(1'b1, 1'b0, 1'b1, 2, 5);   // violation at word 2, response stalled
    issue(1'b0, 1'b0, 1'b0, -1, 0);  // pending unprotect accepted after handshake

    // Reset while in KEY after two writes.
    tick();
    cmd_valid = 1'b1; cmd_enable = 1'b1; t = cyc;
    q_upd.push_back(mk(16'd1, 16'd0, t + 1));
    tick();
    cmd_valid = 1'b0; kd_valid = 1'b1; kd_data = 16'h1111;
    tick();
    tick();
    q_wr.push_back(mk(16'd0, 16'h1111, cyc));
    tick();
    kd_data = 16'h2222;
    q_wr.push_back(mk(16'd1, 16'h2222, cyc));
    tick();
    kd_valid = 1'b0; puc_rst = 1'b1;
    tick();
    puc_rst = 1'b0; kd_valid = 1'b1; kd_data = 16'hDEAD;
    chk("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_kd_ready", 32'(kd_ready), 32'd0);
    chk("postrst_key_idx", 32'(key_idx), 32'd0);
    tick();
    kd_valid = 1'b0;
    issue(1'b1, 1'b0, 1'b0, -1, 0);  // restarts at key_idx 0

    repeat (4) tick();
    chk("left_upd", 32'(q_upd.size()), 32'd0);
    chk("left_wr", 32'(q_wr.size()), 32'd0);
    chk("left_rsp", 32'(q_rsp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/omsp_spm_protect_seq.md
# omsp_spm_protect_seq

Sequencer for the protected-module (SPM) array. It accepts one protect or unprotect command at a time from the execution unit and emits the single-cycle `update_spm`/`enable_spm` pulse that creates or destroys an SPM. It then samples the array's `violation` flag. After a successful protect, it streams the derived module key into the array as 16-bit words over `write_key`/`key_in`/`key_idx`. It sits between the execution unit and `omsp_spm_control` and reports a single pass/fail response per command.

## Interface
Parameters:
- `SECURITY`, 64: key width in bits; must be a multiple of 16.
- `KEY_WORDS`, `SECURITY/16` = 4: number of key words written per protect.
- `KEY_IDX_SIZE`, 2: width of `key_idx`; must satisfy `2**KEY_IDX_SIZE >= KEY_WORDS`.

Ports:
- `mclk`  in  1  clock. One clock domain; all state updates on the rising edge.
- `puc_rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high in IDLE only.
- `cmd_enable`  in  1  1 = protect (create), 0 = unprotect (destroy); sampled on acceptance.
- `update_spm`  out  1  one-cycle update pulse to the SPM array.
- `enable_spm`  out  1  latched `cmd_enable`; meaningful while `update_spm` is high.
- `violation`  in  1  violation flag from the SPM array.
- `kd_valid`  in  1  key-derivation word available.
- `kd_data`  in  16  key-derivation word.
- `kd_ready`  out  1  high in KEY.
- `write_key`  out  1  key write strobe.
- `key_in`  out  16  key word; equals `kd_data` combinationally.
- `key_idx`  out  KEY_IDX_SIZE  key word index.
- `rsp_valid`  out  1  response available.
- `rsp_ok`  out  1  1 = success, 0 = violation/abort.
- `rsp_ready`  in  1  response consumed.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
State machine: IDLE, UPDATE, CHECK, KEY, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch `cmd_enable`, clear the word counter, go to UPDATE.
- UPDATE: `update_spm`=1 for exactly this one cycle, with `enable_spm` = latched value. Go to CHECK.
- CHECK: sample `violation`.
  - `violation`=1: `rsp_ok`←0, go to RESP.
  - Protect with no violation: go to KEY.
  - Unprotect with no violation: `rsp_ok`←1, go to RESP.
- KEY: `kd_ready`=1, `write_key`=`kd_valid`, `key_idx`=counter.
  - Each `kd_valid` cycle writes one word and increments the counter.
  - The write at counter `KEY_WORDS-1` sets `rsp_ok`←1 and goes to RESP.
  - `violation`=1 in any KEY cycle has priority over a same-cycle write: `write_key` is forced to 0, remaining words are dropped, `rsp_ok`←0, go to RESP.
- RESP: `rsp_valid`=1 and `rsp_ok` are held stable until `rsp_ready`, then go to IDLE. A new command can therefore be accepted no earlier than the cycle after the handshake.
- `violation` is ignored in IDLE, UPDATE and RESP.
- Outputs not listed as active in a state are 0. `enable_spm` holds its latched value, but is only meaningful with `update_spm`.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `enable_spm`=0, counter=0, `rsp_ok`=0; every other output 0.
- Reset mid-command: IDLE on the next edge. No further `update_spm` or `write_key` is issued. A partially written key is left as is.
- Protect with `kd_valid` held high:
  - command accepted in cycle T;
  - `update_spm` in T+1;
  - CHECK in T+2;
  - key writes in T+3 … T+2+KEY_WORDS;
  - `rsp_valid` from T+3+KEY_WORDS.
- Unprotect or violation in CHECK: `rsp_valid` from T+3.
- Key-word stalls (`kd_valid`=0) add one cycle each, with no upper bound.
- The counter never wraps within a command; it is cleared on each command acceptance.

## Structure
- Shared package holds:
  - state encoding (5 states, 3 bits);
  - `SECURITY`, already a global define shared with the SPM array;
  - derived `KEY_WORDS`.
- Single module. The state register, counter, latched enable and `rsp_ok` register are all local; no sub-module is warranted.

## Test plan
- Protect, `kd_valid` held, `kd_data` = 0x1111, 0x2222, 0x3333, 0x4444 → `update_spm`=1 with `enable_spm`=1 in T+1; writes at `key_idx` 0..3 with matching data in T+3..T+6; `rsp_valid`/`rsp_ok`=1 in T+7.
- Unprotect (`cmd_enable`=0) → `update_spm`=1 with `enable_spm`=0 in T+1; no `write_key`; `rsp_ok`=1 in T+3.
- Protect, `violation`=1 in CHECK → no `write_key`; `rsp_ok`=0 in T+3.
- Protect, `kd_valid` toggling 1,0,1,0,… → exactly 4 writes, indices strictly 0,1,2,3; then `violation` pulsed together with `kd_valid` at index 2 → index 2 not written; `rsp_ok`=0.
- `rsp_ready` held low 5 cycles → `rsp_valid`/`rsp_ok` stable, `cmd_ready`=0, a new `cmd_valid` is not accepted until the cycle after the handshake.
- `puc_rst` asserted in KEY after 2 writes → next cycle: IDLE, `cmd_ready`=1, `busy`=0, no further writes; a following protect starts again at `key_idx` 0.
